// File: rtl/mm_bst_pkg.sv
// mm_bst_pkg: FSM state type and burst-length decode shared
// by the mm_bst_ram burst RAM and its storage sub-module.
package mm_bst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } bst_state_t;

  // A zero burst count encodes the longest burst, 2**bw words.
  function automatic int unsigned bst_len(
    input int unsigned bcnt,
    input int unsigned bw
  );
    return (bcnt == 0) ? (32'd1 << bw) : bcnt;
  endfunction

endpackage

// File: rtl/mm_bst_sdp_ram.sv
// mm_bst_sdp_ram: simple dual-port RAM, one write port, one
// synchronous read port; read-during-write returns old data.
module mm_bst_sdp_ram
  import mm_bst_pkg::*;
#(
  parameter int    DWIDTH  = 16,
  parameter int    AWIDTH  = 8,
  parameter string RAMTYPE = "AUTO"
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AWIDTH-1:0] i_waddr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AWIDTH-1:0] i_raddr,
  output logic [DWIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] r_rdata;

  assign o_rdata = r_rdata;

  if (RAMTYPE == "AUTO") begin : g_auto
    logic [DWIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
    end
  end else begin : g_typed
    (* ram_style = RAMTYPE *)
    logic [DWIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/mm_bst_ram.sv
// mm_bst_ram: burst write/read front end over a dual-port RAM.
// Define MM_BST_RAM_RDREG_EN to add an output register on s_rdat/s_rval.
module mm_bst_ram
  import mm_bst_pkg::*;
#(
  parameter int    DWIDTH  = 16,
  parameter int    AWIDTH  = 8,
  parameter int    BWIDTH  = 4,
  parameter string RAMTYPE = "AUTO"
) (
  input  logic              reset,
  input  logic              clk,
  input  logic [AWIDTH-1:0] s_addr,
  input  logic [BWIDTH-1:0] s_bcnt,
  input  logic              s_wreq,
  input  logic [DWIDTH-1:0] s_wdat,
  input  logic              s_rreq,
  output logic [DWIDTH-1:0] s_rdat,
  output logic              s_rval,
  output logic              s_busy
);

  localparam int LW = BWIDTH + 1;

  bst_state_t        r_state;
  logic [AWIDTH-1:0] r_addr;
  logic [LW-1:0]     r_cnt;
  logic              r_rval;

  logic [LW-1:0]     w_len;
  logic              w_we;
  logic              w_re;
  logic [AWIDTH-1:0] w_waddr;
  logic [DWIDTH-1:0] w_rdata;

  assign w_len   = LW'(bst_len(32'(s_bcnt), BWIDTH));
  assign w_we    = s_wreq && (r_state != READ);
  assign w_waddr = (r_state == WRITE) ? r_addr : s_addr;
  assign w_re    = (r_state == READ);
  assign s_busy  = w_re;

  // r_addr/r_cnt serve both burst kinds; only one is ever active.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_rval  <= 1'b0;
    end else begin
      r_rval <= (r_state == READ);
      unique case (r_state)
        IDLE: begin
          if (s_wreq) begin
            if (w_len != LW'(1)) begin
              r_state <= WRITE;
              r_cnt   <= w_len - LW'(1);
              r_addr  <= s_addr + AWIDTH'(1);
            end
          end else if (s_rreq) begin
            r_state <= READ;
            r_cnt   <= w_len;
            r_addr  <= s_addr;
          end
        end
        WRITE: begin
          if (s_wreq) begin
            r_addr <= r_addr + AWIDTH'(1);
            r_cnt  <= r_cnt - LW'(1);
            if (r_cnt == LW'(1)) r_state <= IDLE;
          end
        end
        READ: begin
          r_addr <= r_addr + AWIDTH'(1);
          r_cnt  <= r_cnt - LW'(1);
          if (r_cnt == LW'(1)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  mm_bst_sdp_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH),
    .RAMTYPE(RAMTYPE)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(s_wdat),
    .i_re   (w_re),
    .i_raddr(r_addr),
    .o_rdata(w_rdata)
  );

`ifdef MM_BST_RAM_RDREG_EN
  logic [DWIDTH-1:0] r_rdat;
  logic              r_rval2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdat  <= '0;
      r_rval2 <= 1'b0;
    end else begin
      r_rdat  <= w_rdata;
      r_rval2 <= r_rval;
    end
  end

  assign s_rdat = r_rdat;
  assign s_rval = r_rval2;
`else
  assign s_rdat = w_rdata;
  assign s_rval = r_rval;
`endif

endmodule

// File: tb/tb_mm_bst_ram.sv
// tb_mm_bst_ram: random and directed bursts checked every cycle
// against a word-level model of the burst RAM.
module tb_mm_bst_ram;

`ifdef MM_BST_RAM_RDREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_addr = '0;
  logic [3:0]  s_bcnt = '0;
  logic        s_wreq = 1'b0;
  logic [15:0] s_wdat = '0;
  logic        s_rreq = 1'b0;
  logic [15:0] s_rdat;
  logic        s_rval;
  logic        s_busy;

  mm_bst_ram #(
    .DWIDTH (16),
    .AWIDTH (8),
    .BWIDTH (4),
    .RAMTYPE("AUTO")
  ) dut (
    .reset (rst_n),
    .clk   (clk),
    .s_addr(s_addr),
    .s_bcnt(s_bcnt),
    .s_wreq(s_wreq),
    .s_wdat(s_wdat),
    .s_rreq(s_rreq),
    .s_rdat(s_rdat),
    .s_rval(s_rval),
    .s_busy(s_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] mm [256];
  bit          known [256];
  int          rd_left, wr_left;
  logic [7:0]  ra, wa;
  bit          exp_v, exp_k, exp_busy, pv, pk;
  logic [15:0] exp_d, pd;

  int          log_cyc [$];
  logic [15:0] log_dat [$];
  int          busy_cnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Word-level model: bursts as counters over an array.
  initial begin
    int          len;
    bit          iv, ik;
    logic [15:0] id;
    rd_left = 0; wr_left = 0;
    exp_v = 0; exp_k = 0; exp_busy = 0; pv = 0; pk = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        rd_left = 0; wr_left = 0;
        exp_v = 0; exp_k = 0; exp_busy = 0; pv = 0; pk = 0;
      end else begin
        len = (s_bcnt == 0) ? 16 : int'(s_bcnt);
        iv = 0; ik = 0; id = '0;
        if (rd_left > 0) begin
          iv = 1; ik = known[ra]; id = mm[ra];
          ra++; rd_left--;
        end else if (wr_left > 0) begin
          if (s_wreq) begin
            mm[wa] = s_wdat; known[wa] = 1;
            wa++; wr_left--;
          end
        end else if (s_wreq) begin
          mm[s_addr] = s_wdat; known[s_addr] = 1;
          wr_left = len - 1; wa = s_addr + 8'd1;
        end else if (s_rreq) begin
          rd_left = len; ra = s_addr;
        end
        if (LAT == 3) begin
          exp_v = pv; exp_k = pk; exp_d = pd;
          pv = iv; pk = ik; pd = id;
        end else begin
          exp_v = iv; exp_k = ik; exp_d = id;
        end
        exp_busy = (rd_left > 0);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("busy", s_busy, exp_busy);
    chk("rval", s_rval, exp_v);
    if (exp_v && exp_k && s_rval) chk("rdat", s_rdat, exp_d);
    if (s_rval) begin
      log_cyc.push_back(cyc);
      log_dat.push_back(s_rdat);
    end
    if (s_busy) busy_cnt++;
  end

  task automatic step(input bit w, input bit r, input logic [7:0] a,
                      input logic [3:0] b, input logic [15:0] d);
    s_wreq = w; s_rreq = r; s_addr = a; s_bcnt = b; s_wdat = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 8'h00, 4'h0, 16'h0000);
  endtask

  task automatic clr_log();
    log_cyc.delete();
    log_dat.delete();
    busy_cnt = 0;
  endtask

  function automatic int lc(input int i);
    return (i < log_cyc.size()) ? log_cyc[i] : -1;
  endfunction

  function automatic logic [15:0] ld(input int i);
    return (i < log_dat.size()) ? log_dat[i] : 16'hxxxx;
  endfunction

  logic [15:0] e1 [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
  logic [15:0] e2 [4] = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h0101};

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    chk("rst_busy", s_busy, 0);
    chk("rst_rval", s_rval, 0);
`ifdef MM_BST_RAM_RDREG_EN
    chk("rst_rdat", s_rdat, 0);
`endif
    #2 rst_n = 1'b1;
    @(negedge clk);

    // four-word write then read back with exact timing
    step(1, 0, 8'h10, 4'd4, 16'h0011);
    step(1, 0, 8'h00, 4'd0, 16'h0022);
    step(1, 0, 8'h00, 4'd0, 16'h0033);
    step(1, 0, 8'h00, 4'd0, 16'h0044);
    clr_log();
    t0 = cyc;
    step(0, 1, 8'h10, 4'd4, 16'h0000);
    idle(LAT + 6);
    chk("t1_count", log_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_cyc", lc(i), t0 + LAT + i);
      chk("t1_dat", ld(i), e1[i]);
    end

    // stalled write burst across the address wrap
    step(1, 0, 8'h01, 4'd1, 16'h0101);
    step(1, 0, 8'hFE, 4'd3, 16'h00A1);
    step(0, 0, 8'h55, 4'd7, 16'hDEAD);
    step(0, 0, 8'h56, 4'd2, 16'hBEEF);
    step(1, 0, 8'h55, 4'd7, 16'h00A2);
    step(1, 0, 8'h00, 4'd0, 16'h00A3);
    clr_log();
    step(0, 1, 8'hFE, 4'd4, 16'h0000);
    idle(LAT + 6);
    chk("t2_count", log_dat.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_dat", ld(i), e2[i]);

    // zero burst count means sixteen words
    clr_log();
    step(0, 1, 8'h00, 4'd0, 16'h0000);
    idle(24);
    chk("t3_count", log_cyc.size(), 16);
    chk("t3_busy", busy_cnt, 16);
    chk("t3_d0", ld(0), 16'h00A3);
    chk("t3_d1", ld(1), 16'h0101);

    // simultaneous requests: write first, read next cycle
    clr_log();
    t0 = cyc;
    step(1, 1, 8'h40, 4'd1, 16'h5A5A);
    step(0, 1, 8'h40, 4'd1, 16'h0000);
    idle(LAT + 4);
    chk("t4_count", log_cyc.size(), 1);
    chk("t4_cyc", lc(0), t0 + 1 + LAT);
    chk("t4_dat", ld(0), 16'h5A5A);

    // reset in the middle of an eight-word read
    step(1, 0, 8'h80, 4'd8, 16'h8000);
    for (int i = 1; i < 8; i++) step(1, 0, 8'h00, 4'd0, 16'h8000 + 16'(i));
    clr_log();
    t0 = cyc;
    step(0, 1, 8'h80, 4'd8, 16'h0000);
    while (cyc < t0 + LAT + 2) idle(1);
    chk("t5_pre_rval", s_rval, 1);
    chk("t5_pre_dat", s_rdat, 16'h8002);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_rval", s_rval, 0);
    chk("t5_rst_busy", s_busy, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    clr_log();
    idle(12);
    chk("t5_post", log_cyc.size(), 0);
    step(0, 1, 8'h80, 4'd2, 16'h0000);
    idle(LAT + 4);
    chk("t5_keep0", ld(0), 16'h8000);
    chk("t5_keep1", ld(1), 16'h8001);

    // random traffic around the wrap point
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
      end
      step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
           8'(32'hF0 + $urandom_range(0, 31)),
           4'($urandom_range(0, 15)), 16'($urandom));
    end
    idle(LAT + 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mm_bst_ram.md
MM_BST_RAM -- requirements
Module: mm_bst_ram

Interface
REQ-001 DWIDTH, default 16, data word width.
REQ-002 AWIDTH, default 8, word address width; memory depth 2**AWIDTH words.
REQ-003 BWIDTH, default 4, burst count width.
REQ-004 RAMTYPE, default "AUTO", storage resource type passed to the RAM.
REQ-005 reset  in  1  async active-low reset; low = reset.
REQ-006 clk  in  1  the single clock; all logic on its rising edge.
REQ-007 s_addr  in  AWIDTH  burst start word address; sampled on burst accept only.
REQ-008 s_bcnt  in  BWIDTH  burst length; N = N words, 0 = 2**BWIDTH words; sampled on accept only.
REQ-009 s_wreq  in  1  write beat request.
REQ-010 s_wdat  in  DWIDTH  write beat data.
REQ-011 s_rreq  in  1  read burst request.
REQ-012 s_rdat  out  DWIDTH  read data.
REQ-013 s_rval  out  1  s_rdat valid strobe; one pulse per read word.
REQ-014 s_busy  out  1  request not accepted this cycle.

Function
REQ-015 FSM states IDLE, WRITE, READ shall exist; s_busy shall be 1 exactly in READ.
REQ-016 In IDLE, s_wreq=1 shall accept a write burst: word s_wdat stored at s_addr; if the burst is 1 word, stay IDLE; else go WRITE with remaining = length-1, next address = s_addr+1.
REQ-017 In WRITE, each cycle with s_wreq=1 shall store one word at the next address and decrement remaining; return to IDLE after the last word; s_wreq=0 shall stall without state change.
REQ-018 In IDLE with s_wreq=0 and s_rreq=1, a read burst shall be accepted: latch address and length, go READ next cycle.
REQ-019 s_wreq and s_rreq both 1 in IDLE: write wins; the read stays pending while s_rreq remains high.
REQ-020 s_rreq in WRITE shall be ignored; s_wreq and s_rreq in READ shall be ignored (s_busy=1).
REQ-021 In READ, one RAM read address shall issue per cycle, no gaps; after the last one, return to IDLE next cycle.
REQ-022 Read latency: accept at cycle T -> addresses at T+1..T+N -> s_rval at T+2..T+N+1, in address order.
REQ-023 Addresses shall increment by 1 per word, modulo 2**AWIDTH (0xFF -> 0x00 at AWIDTH=8).
REQ-024 Read and write ports are independent: a write may start in IDLE while read data of the previous burst is still in the pipe. Same-address read-during-write returns old data.
REQ-025 s_rdat outside s_rval is don't-care.

Reset
REQ-026 Asserting reset shall force IDLE, counters 0, s_busy=0, s_rval=0, s_rdat=0 (registered variant) asynchronously.
REQ-027 Reset mid-burst shall abort the burst and discard pipelined read words; no s_rval after release until a new read is accepted.
REQ-028 RAM contents shall not be reset.

Configuration
REQ-029 Macro MM_BST_RAM_RDREG_EN defined: one extra output register on s_rdat/s_rval; read latency +1 (s_rval at T+3..T+N+2).
REQ-030 Macro undefined: latency per REQ-022; s_rdat is the RAM output directly.

Structure
REQ-031 Package mm_bst_pkg shall hold the FSM state typedef (IDLE, WRITE, READ) and the burst-length decode function (0 -> 2**BWIDTH).
REQ-032 Storage shall be one sub-module mm_bst_sdp_ram: simple dual-port, one write and one read port, synchronous read, RAMTYPE passed through.

Verification
REQ-033 Write 4 words 0x11,0x22,0x33,0x44 at addr 0x10 with bcnt=4, then read bcnt=4 at 0x10 -> rval on 4 consecutive cycles, T+2..T+5, data 0x11..0x44.
REQ-034 Write burst at 0xFE with bcnt=3 stalled by s_wreq=0 for 2 cycles mid-burst, then read back -> words at 0xFE,0xFF,0x00; stall shows no spurious writes.
REQ-035 bcnt=0 read (BWIDTH=4) -> exactly 16 rval pulses; s_busy high for exactly 16 cycles.
REQ-036 s_wreq=s_rreq=1 in IDLE with 1-word bursts -> write done first; read accepted next cycle and returns the just-written value.
REQ-037 Reset asserted at the 3rd word of an 8-word read -> s_rval=0 and s_busy=0 at once; no rval after release.
REQ-038 Repeat REQ-033 with MM_BST_RAM_RDREG_EN -> same data, rval at T+3..T+6.
